hex_scan_ctrl: RTL and testbench

- Shares one external combinational dec7seg instance across the six DE1-SoC seven-segment digits.
- On each accepted load, sequences the six nibbles through the shared decoder, one per cycle, and latches each result into a per-digit segment register.
- Adds per-digit blanking and blinking.
- Sits between the user logic (which produces a 24-bit value) and the fpga top-level hex0..hex5 outputs.

---
 rtl/hex_scan_ctrl.sv | 148 ++++++++++++++
 tb/tb_hex_scan_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/hex_scan_ctrl.sv
// Six-digit seven-segment scan controller: time-shares one external dec7seg across
// hex0..hex5, latching each decoded pattern into a per-digit register, with blank/blink.
module hex_scan_ctrl #(
    parameter int NDIG      = 6,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [23:0] value,
    input  logic [5:0]  blank,
    input  logic [5:0]  blink,
    output logic        busy,
    output logic [3:0]  dec_i,
    input  logic [6:0]  dec_o,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5
);
    // Handshake: a load is accepted on a rising clk edge where load_valid and
    // load_ready are both high; load_ready is high exactly when the controller is IDLE.

    localparam int            CW       = $clog2(BLINK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);
    localparam logic [2:0]    IDX_LAST = 3'(NDIG - 1);
    localparam logic [6:0]    SEG_OFF  = 7'h7F;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [2:0]    idx;
    logic [23:0]   shadow_value;
    logic [5:0]    shadow_blank;
    logic [5:0]    shadow_blink;
    logic [6:0]    seg_reg [NDIG];
    logic [6:0]    hex_out [NDIG];
    logic [CW-1:0] blink_cnt;
    logic          phase;
    logic [3:0]    scan_nib;
    logic          accept;

    assign accept = load_valid && load_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (load_valid) state_next = SCAN;
            SCAN: if (idx == IDX_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load_ready = 1'b0;
        busy       = 1'b0;
        dec_i      = 4'h0;
        case (state)
            IDLE: load_ready = 1'b1;
            SCAN: begin
                busy  = 1'b1;
                dec_i = scan_nib;
            end
            default: load_ready = 1'b0;
        endcase
    end

    always_comb begin
        scan_nib = 4'h0;
        case (idx)
            3'd0: scan_nib = shadow_value[3:0];
            3'd1: scan_nib = shadow_value[7:4];
            3'd2: scan_nib = shadow_value[11:8];
            3'd3: scan_nib = shadow_value[15:12];
            3'd4: scan_nib = shadow_value[19:16];
            3'd5: scan_nib = shadow_value[23:20];
            default: scan_nib = 4'h0;
        endcase
    end

    // Shadow copies make the load inputs don't-care once the scan has started.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx          <= 3'd0;
            shadow_value <= 24'h0;
            shadow_blank <= 6'h0;
            shadow_blink <= 6'h0;
        end else if (state == SCAN) begin
            idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
        end else if (accept) begin
            idx          <= 3'd0;
            shadow_value <= value;
            shadow_blank <= blank;
            shadow_blink <= blink;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NDIG; k++) seg_reg[k] <= SEG_OFF;
        end else if (state == SCAN) begin
            for (int k = 0; k < NDIG; k++) begin
                if (idx == 3'(k)) seg_reg[k] <= shadow_blank[k] ? SEG_OFF : dec_o;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == CNT_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    always_comb begin
        for (int k = 0; k < NDIG; k++) begin
            hex_out[k] = (shadow_blink[k] && phase) ? SEG_OFF : seg_reg[k];
        end
    end

    assign hex0 = hex_out[0];
    assign hex1 = hex_out[1];
    assign hex2 = hex_out[2];
    assign hex3 = hex_out[3];
    assign hex4 = hex_out[4];
    assign hex5 = hex_out[5];

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Bench for hex_scan_ctrl: driver issues loads, an expected-response queue feeds a
// negedge monitor that checks dec_i, scan timing and the six displayed patterns.
module tb_hex_scan_ctrl;
    localparam int BLINK_DIV = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic        load_ready;
    logic [23:0] value;
    logic [5:0]  blank;
    logic [5:0]  blink;
    logic        busy;
    logic [3:0]  dec_i;
    logic [6:0]  dec_o;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

    int n_tests = 0;
    int n_fail  = 0;
    int ncyc;

    // Entry layout: {value[23:0], blink[5:0], segs[41:0]}, digit k at segs[7k+:7].
    logic [71:0] exp_q[$];
    int          gap_q[$];

    hex_scan_ctrl #(.NDIG(6), .BLINK_DIV(BLINK_DIV)) dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
        .value(value), .blank(blank), .blink(blink), .busy(busy),
        .dec_i(dec_i), .dec_o(dec_o),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dec7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    assign dec_o = dec7(dec_i);

    function automatic logic [41:0] final_segs(input logic [23:0] v, input logic [5:0] b);
        logic [41:0] r;
        for (int k = 0; k < 6; k++) r[7*k +: 7] = b[k] ? 7'h7F : dec7(v[4*k +: 4]);
        return r;
    endfunction

    function automatic logic [41:0] shown(input logic [41:0] s, input logic [5:0] bm, input int cyc);
        logic [41:0] r;
        bit ph;
        ph = ((cyc / BLINK_DIV) % 2) != 0;
        for (int k = 0; k < 6; k++) r[7*k +: 7] = (bm[k] && ph) ? 7'h7F : s[7*k +: 7];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Edges since reset release; the blink phase is (ncyc / BLINK_DIV) mod 2.
    always @(posedge clk or posedge reset) begin
        if (reset) ncyc <= 0;
        else       ncyc <= ncyc + 1;
    end

    // ---------------- driver ----------------
    task automatic do_load(input logic [23:0] v, input logic [5:0] b, input logic [5:0] k,
                           input int gap, input bit keep);
        logic r;
        bit   done;
        done = 0;
        @(negedge clk);
        value = v; blank = b; blink = k; load_valid = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            r = load_ready;
            @(posedge clk);
            if (r) begin
                exp_q.push_back({v, k, final_segs(v, b)});
                gap_q.push_back(gap);
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) check("accept_timeout", 64'd0, 64'd1);
        if (!keep) begin
            @(negedge clk);
            load_valid = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- monitor ----------------
    logic [41:0] mon_seg;
    logic [5:0]  mon_blink;
    logic [71:0] cur;
    bit          in_scan;
    int          scan_pos;
    int          last_start;
    int          gap;

    always @(negedge clk or posedge reset) begin
        if (reset) begin
            #1;
            check("reset_hex", {hex5, hex4, hex3, hex2, hex1, hex0}, {6{7'h7F}});
            check("reset_busy", busy, 1'b0);
            check("reset_ready", load_ready, 1'b1);
            check("reset_dec_i", dec_i, 4'h0);
            mon_seg   = {6{7'h7F}};
            mon_blink = 6'h0;
            in_scan   = 0;
            scan_pos  = 0;
        end else if (busy) begin
            if (!in_scan) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_scan", 64'd0, 64'd1);
                    cur = '0;
                    gap = -1;
                end else begin
                    cur = exp_q.pop_front();
                    gap = gap_q.pop_front();
                end
                if (gap >= 0) check("accept_gap", ncyc - last_start, gap);
                last_start = ncyc;
                mon_blink  = cur[47:42];
                in_scan    = 1;
                scan_pos   = 0;
            end else if (scan_pos >= 5) begin
                check("scan_len", scan_pos + 2, 6);
            end else begin
                mon_seg[7*scan_pos +: 7] = cur[7*scan_pos +: 7];
                scan_pos++;
            end
            check("dec_i", dec_i, cur[48 + 4*scan_pos +: 4]);
            check("ready_in_scan", load_ready, 1'b0);
            check("hex_scan", {hex5, hex4, hex3, hex2, hex1, hex0}, shown(mon_seg, mon_blink, ncyc));
        end else begin
            if (in_scan) begin
                check("scan_len", scan_pos + 1, 6);
                mon_seg[35 +: 7] = cur[35 +: 7];
                in_scan = 0;
            end
            check("ready_idle", load_ready, 1'b1);
            check("dec_i_idle", dec_i, 4'h0);
            check("hex_idle", {hex5, hex4, hex3, hex2, hex1, hex0}, shown(mon_seg, mon_blink, ncyc));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit keep;
        bit prev_keep;
        reset = 1'b1; load_valid = 1'b0; value = '0; blank = '0; blink = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        do_load(24'h123456, 6'h00, 6'h00, -1, 0);
        repeat (10) @(negedge clk);

        do_load(24'hABCDEF, 6'h00, 6'h00, -1, 1);
        do_load(24'h000000, 6'h00, 6'h00, 7, 0);
        repeat (10) @(negedge clk);

        do_load(24'h888888, 6'b100001, 6'h00, -1, 0);
        repeat (10) @(negedge clk);

        do_load(24'h000000, 6'h00, 6'b000010, -1, 0);
        repeat (24) @(negedge clk);

        do_load(24'h777777, 6'b000010, 6'b000011, -1, 0);
        repeat (16) @(negedge clk);

        pulse_reset();
        repeat (3) @(negedge clk);

        do_load(24'h654321, 6'h00, 6'b000100, -1, 0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        do_load(24'h13579B, 6'h00, 6'h00, -1, 0);
        repeat (10) @(negedge clk);

        prev_keep = 0;
        for (int i = 0; i < 150; i++) begin
            keep = (i < 149) && ($urandom_range(0, 3) == 0);
            do_load($urandom, ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h00, 6'($urandom),
                    prev_keep ? 7 : -1, keep);
            if (!keep) repeat ($urandom_range(0, 8)) @(negedge clk);
            prev_keep = keep;
        end

        repeat (12) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
